div_controller: RTL and testbench
=================================

DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width in bits (legal 4..128).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled only on the rising edge of clk.
REQ-004 Port: op_start  input  1  start request; sampled high in IDLE or DONE, it captures the operands.
REQ-005 Port: dividend  input  WIDTH  signed two's-complement dividend, captured with op_start.
REQ-006 Port: divisor  input  WIDTH  signed two's-complement divisor, captured with op_start.
REQ-007 Port: quotient  output  WIDTH  signed quotient, registered.
REQ-008 Port: remainder  output  WIDTH  signed remainder, registered.
REQ-009 Port: op_done  output  1  result valid; held high until next op_start or reset.
REQ-010 Port: busy  output  1  high in PREP, RUN and FIX.
REQ-011 Port: div_by_zero  output  1  set with op_done when captured divisor was 0.

Function
REQ-012 The FSM SHALL have states IDLE, PREP, RUN, FIX and DONE, with IDLE as the reset state.
REQ-013 IDLE/DONE + op_start=1 at edge k: operands are captured, op_done=0, div_by_zero=0, and the next state is PREP; quotient/remainder keep their old values until FIX.
REQ-014 PREP (edge k+1): magnitudes |dividend| and |divisor| are loaded as WIDTH-bit unsigned values, sign flags are stored, the 8-bit iteration counter is cleared to 0, and the next state is RUN; if divisor==0 the next state is DONE instead.
REQ-015 RUN: one restoring step per cycle, as follows.
- Shift {partial_rem, dividend_mag} left by 1.
- Trial-subtract divisor_mag using WIDTH+1 bits.
- If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
- Increment the counter.
REQ-016 RUN SHALL exit to FIX on the edge where the counter reaches WIDTH, so there are exactly WIDTH iterations.
REQ-017 FIX: the quotient is negated if the dividend and divisor signs differ, and the remainder is negated if the dividend was negative; results are registered and the next state is DONE.
REQ-018 DONE asserts op_done=1 from edge k+WIDTH+3, giving a total latency of WIDTH+3 edges from the start edge.
REQ-019 Divide by zero: at edge k+2 the block SHALL set quotient = all ones, remainder = captured dividend, div_by_zero=1 and op_done=1.
REQ-020 Overflow case (dividend = -2^(WIDTH-1), divisor = -1): quotient = -2^(WIDTH-1) (wraps), remainder = 0, no flag.
REQ-021 op_start while busy=1 SHALL be ignored; operands and progress are unaffected.
REQ-022 op_start held high in DONE SHALL start one new operation per sampled edge in DONE only; it does not retrigger while busy.
REQ-023 The identity dividend == quotient*divisor + remainder (mod 2^WIDTH) SHALL hold, with |remainder| < |divisor| and the remainder sign equal to the dividend sign, for every divisor != 0.
REQ-024 No combinational path SHALL exist from any input to any output.

Reset
REQ-025 reset=1 at an edge SHALL force the following: state=IDLE, quotient=0, remainder=0, op_done=0, busy=0, div_by_zero=0, counter=0.
REQ-026 reset SHALL override op_start on the same edge.
REQ-027 reset mid-RUN SHALL abort the operation, leaving no partial result visible.

Verification
REQ-028 WIDTH=8, 100/7 -> quotient=14, remainder=2, op_done high at start edge +11, busy low.
REQ-029 WIDTH=8, -100/7 -> quotient=-14, remainder=-2; 100/-7 -> quotient=-14, remainder=2.
REQ-030 WIDTH=8, 7/0 -> quotient=8'hFF, remainder=7, div_by_zero=1, op_done at start edge +2.
REQ-031 WIDTH=8, -128/-1 -> quotient=-128, remainder=0; WIDTH=64, (2^63-1)/3 -> quotient=3074457345618258602, remainder=1, op_done at start edge +67.
REQ-032 Pulse op_start mid-RUN with new operands -> original result unchanged; reset asserted at the 4th RUN edge -> all outputs 0, state IDLE, and the next op_start gives a correct result.
REQ-033 Random signed operands (WIDTH=8 exhaustive, WIDTH=64 >=10k) -> REQ-023 holds on every op_done.

Source files
------------

// File: rtl/div_controller.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient bit per cycle,
// with sign fix-up at the end. All outputs are registered; state is mirrored on dbg_state.
module div_controller #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             op_done,
  output logic             busy,
  output logic             div_by_zero,
  output logic [2:0]       dbg_state
);

  // Handshake: op_start is a request sampled only in IDLE/DONE; op_done is a level that stays
  // high from result availability until the next accepted op_start or reset.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic             op_done_q, op_done_d;
  logic             busy_q, busy_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d       = state_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    rem_d         = rem_q;
    acc_d         = acc_q;
    mag_d         = mag_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    cnt_d         = cnt_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dz_d          = dz_q;
    op_done_d     = op_done_q;
    div_by_zero_d = div_by_zero_q;
    // acc holds the dividend magnitude; quotient bits shift in from the bottom as it empties.
    shifted       = {rem_q, acc_q[WIDTH-1]};
    trial         = shifted - {1'b0, mag_q};

    case (state_q)
      IDLE, DONE: begin
        if (op_start) begin
          dvd_d         = dividend;
          dvs_d         = divisor;
          op_done_d     = 1'b0;
          div_by_zero_d = 1'b0;
          state_d       = PREP;
        end else if (state_q == DONE) begin
          op_done_d     = 1'b1;
          div_by_zero_d = dz_q;
          if (dz_q) begin
            quotient_d  = '1;
            remainder_d = dvd_q;
          end
        end
      end
      PREP: begin
        acc_d     = dvd_q[WIDTH-1] ? -dvd_q : dvd_q;
        mag_d     = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
        rem_d     = '0;
        cnt_d     = 8'd0;
        neg_quo_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
        neg_rem_d = dvd_q[WIDTH-1];
        dz_d      = (dvs_q == '0);
        state_d   = dz_d ? DONE : RUN;
      end
      RUN: begin
        acc_d = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == 8'(WIDTH)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = neg_quo_q ? -acc_q : acc_q;
        remainder_d = neg_rem_q ? -rem_q : rem_q;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PREP) || (state_d == RUN) || (state_d == FIX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      acc_q         <= '0;
      mag_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      cnt_q         <= 8'd0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dz_q          <= 1'b0;
      op_done_q     <= 1'b0;
      busy_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      rem_q         <= rem_d;
      acc_q         <= acc_d;
      mag_q         <= mag_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      cnt_q         <= cnt_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dz_q          <= dz_d;
      op_done_q     <= op_done_d;
      busy_q        <= busy_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign op_done     = op_done_q;
  assign busy        = busy_q;
  assign div_by_zero = div_by_zero_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_div_controller.sv
// Directed and randomized checks of div_controller at WIDTH=8 and WIDTH=64.
module tb_div_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-bit instance signals
  logic       rst8, start8, done8, busy8, dz8;
  logic [7:0] a8, b8, q8, r8;
  logic [2:0] st8;
  // 64-bit instance signals
  logic        rst64, start64, done64, busy64, dz64;
  logic [63:0] a64, b64, q64, r64;
  logic [2:0]  st64;

  div_controller #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .op_start(start8), .dividend(a8), .divisor(b8),
    .quotient(q8), .remainder(r8), .op_done(done8), .busy(busy8),
    .div_by_zero(dz8), .dbg_state(st8)
  );

  div_controller #(.WIDTH(64)) u64 (
    .clk(clk), .reset(rst64), .op_start(start64), .dividend(a64), .divisor(b64),
    .quotient(q64), .remainder(r64), .op_done(done64), .busy(busy64),
    .div_by_zero(dz64), .dbg_state(st64)
  );

  // dividend, divisor, quotient, remainder (hand-computed, truncating division)
  localparam logic [7:0] V_A [9] = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'd127, 8'd5,  8'h80, 8'd127};
  localparam logic [7:0] V_B [9] = '{8'd7,   8'd7,  8'hF9,  8'hF9, 8'hFF, 8'd1,   8'd9,  8'd127, 8'h80};
  localparam logic [7:0] V_Q [9] = '{8'd14,  8'hF2, 8'hF2,  8'd14, 8'h80, 8'd127, 8'd0,  8'hFF, 8'd0};
  localparam logic [7:0] V_R [9] = '{8'd2,   8'hFE, 8'd2,   8'hFE, 8'd0,  8'd0,   8'd5,  8'hFF, 8'd127};

  // Reference: truncating signed division; divisor -1 handled by negation so the
  // most-negative dividend wraps instead of trapping.
  function automatic void model(input longint a, input longint b,
                                output longint q, output longint r);
    if (b == 0) begin
      q = -1;
      r = a;
    end else if (b == -1) begin
      q = -a;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b, output int lat);
    @(negedge clk);
    a64 = a; b64 = b; start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (done64) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst8 = 1'b1; rst64 = 1'b1; start8 = 1'b1; start64 = 1'b1;
    a8 = 8'd9; b8 = 8'd3; a64 = 64'd9; b64 = 64'd3;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({q8, r8, done8, busy8, dz8, st8} !== 22'd0) begin
      n_errors++;
      $display("FAIL reset8: got q=%h r=%h done=%b busy=%b dz=%b st=%0d, expected all 0", q8, r8, done8, busy8, dz8, st8);
    end
    n_checks++;
    if (q64 !== 64'd0 || r64 !== 64'd0 || {done64, busy64, dz64, st64} !== 6'd0) begin
      n_errors++;
      $display("FAIL reset64: got q=%h r=%h done=%b busy=%b dz=%b st=%0d, expected all 0", q64, r64, done64, busy64, dz64, st64);
    end
    @(negedge clk);
    rst8 = 1'b0; rst64 = 1'b0; start8 = 1'b0; start64 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (st8 !== 3'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_errors++;
      $display("FAIL idle8: got st=%0d busy=%b done=%b, expected st=0 busy=0 done=0", st8, busy8, done8);
    end
  endtask

  task automatic test_basic8();
    int lat;
    for (int i = 0; i < 9; i++) begin
      op8(V_A[i], V_B[i], lat);
      n_checks++;
      if (lat !== 11) begin
        n_errors++;
        $display("FAIL basic8[%0d] latency: got %0d expected 11", i, lat);
      end
      n_checks++;
      if (q8 !== V_Q[i] || r8 !== V_R[i]) begin
        n_errors++;
        $display("FAIL basic8[%0d] result: got q=%h r=%h expected q=%h r=%h", i, q8, r8, V_Q[i], V_R[i]);
      end
      n_checks++;
      if (busy8 !== 1'b0 || dz8 !== 1'b0) begin
        n_errors++;
        $display("FAIL basic8[%0d] flags: got busy=%b dz=%b expected 0 0", i, busy8, dz8);
      end
    end
  endtask

  task automatic test_div_zero8();
    int lat;
    op8(8'd7, 8'd0, lat);
    n_checks++;
    if (lat !== 2 || q8 !== 8'hFF || r8 !== 8'd7 || dz8 !== 1'b1) begin
      n_errors++;
      $display("FAIL divzero8 7/0: got lat=%0d q=%h r=%h dz=%b expected lat=2 q=ff r=07 dz=1", lat, q8, r8, dz8);
    end
    op8(8'hFB, 8'd0, lat);
    n_checks++;
    if (lat !== 2 || q8 !== 8'hFF || r8 !== 8'hFB || dz8 !== 1'b1) begin
      n_errors++;
      $display("FAIL divzero8 -5/0: got lat=%0d q=%h r=%h dz=%b expected lat=2 q=ff r=fb dz=1", lat, q8, r8, dz8);
    end
    op8(8'd9, 8'd4, lat);
    n_checks++;
    if (lat !== 11 || q8 !== 8'd2 || r8 !== 8'd1 || dz8 !== 1'b0) begin
      n_errors++;
      $display("FAIL divzero8 clear: got lat=%0d q=%h r=%h dz=%b expected lat=11 q=02 r=01 dz=0", lat, q8, r8, dz8);
    end
  endtask

  task automatic test_wide64();
    int lat;
    op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd3, lat);
    n_checks++;
    if (lat !== 67 || q64 !== 64'd3074457345618258602 || r64 !== 64'd1) begin
      n_errors++;
      $display("FAIL wide64 max/3: got lat=%0d q=%0d r=%0d expected lat=67 q=3074457345618258602 r=1", lat, q64, r64);
    end
    op64(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    n_checks++;
    if (lat !== 67 || q64 !== 64'h8000_0000_0000_0000 || r64 !== 64'd0 || dz64 !== 1'b0) begin
      n_errors++;
      $display("FAIL wide64 overflow: got lat=%0d q=%h r=%h dz=%b expected lat=67 q=8000000000000000 r=0 dz=0", lat, q64, r64, dz64);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    repeat (3) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_ignore busy: got %b expected 1", busy8);
    end
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat++;
    for (int n = 0; n < 200 && !done8; n++) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 11 || q8 !== 8'd14 || r8 !== 8'd2) begin
      n_errors++;
      $display("FAIL busy_ignore result: got lat=%0d q=%h r=%h expected lat=11 q=0e r=02", lat, q8, r8);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    // Start straight out of DONE and hold op_start while the operands change underneath.
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd2; start8 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      n_errors++;
      $display("FAIL back_to_back start: got busy=%b done=%b expected busy=1 done=0", busy8, done8);
    end
    a8 = 8'd77; b8 = 8'd5;
    lat = 0;
    repeat (3) begin
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b0;
    for (int n = 0; n < 200 && !done8; n++) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat !== 11 || q8 !== 8'd4 || r8 !== 8'd1) begin
      n_errors++;
      $display("FAIL back_to_back result: got lat=%0d q=%h r=%h expected lat=11 q=04 r=01", lat, q8, r8);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({q8, r8, done8, busy8, dz8, st8} !== 22'd0) begin
      n_errors++;
      $display("FAIL reset_mid_run: got q=%h r=%h done=%b busy=%b dz=%b st=%0d, expected all 0", q8, r8, done8, busy8, dz8, st8);
    end
    @(negedge clk);
    rst8 = 1'b0;
    op8(8'h9C, 8'd7, lat);
    n_checks++;
    if (lat !== 11 || q8 !== 8'hF2 || r8 !== 8'hFE) begin
      n_errors++;
      $display("FAIL reset_mid_run recover: got lat=%0d q=%h r=%h expected lat=11 q=f2 r=fe", lat, q8, r8);
    end
  endtask

  task automatic test_random8();
    int lat;
    longint eq, er;
    logic [7:0] a, b;
    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (i % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      model(longint'($signed(a)), longint'($signed(b)), eq, er);
      op8(a, b, lat);
      n_checks++;
      if (q8 !== eq[7:0] || r8 !== er[7:0] || dz8 !== (b == 8'd0) || lat !== ((b == 8'd0) ? 2 : 11)) begin
        n_errors++;
        $display("FAIL random8 %h/%h: got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h", a, b, q8, r8, dz8, lat, eq[7:0], er[7:0]);
      end
    end
  endtask

  task automatic test_random64();
    int lat;
    longint eq, er;
    logic [63:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      b = $signed(b) >>> $urandom_range(0, 62);
      if (i % 20 == 7) b = 64'd0;
      model(longint'(a), longint'(b), eq, er);
      op64(a, b, lat);
      n_checks++;
      if (q64 !== 64'(eq) || r64 !== 64'(er) || dz64 !== (b == 64'd0) || lat !== ((b == 64'd0) ? 2 : 67)) begin
        n_errors++;
        $display("FAIL random64 %h/%h: got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h", a, b, q64, r64, dz64, lat, eq, er);
      end
    end
  endtask

  initial begin
    rst8 = 1'b1; rst64 = 1'b1; start8 = 1'b0; start64 = 1'b0;
    a8 = '0; b8 = '0; a64 = '0; b64 = '0;
    test_reset();
    test_basic8();
    test_div_zero8();
    test_wide64();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random8();
    test_random64();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
